// File: rtl/lcd_hd44780_writer.sv
// Write-only HD44780 bus engine: power-up init sequence, then single
// command/data bytes over valid/ready, each strobed onto the panel with
// setup, enable-pulse, hold and execution-wait timing from one shared counter.
module lcd_hd44780_writer #(
  parameter int POWERUP_CYC  = 2_000_000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_PULSE_CYC = 25,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2_500,
  parameter int CLR_WAIT_CYC = 100_000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                     max2(EN_PULSE_CYC, HOLD_CYC)),
                                max2(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CW = $clog2(MAX_CYC) + 1;

  // Counter reload values: the counter runs N-1 .. 0, so each phase lasts N cycles.
  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(EN_PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT_CYC - 1);

  localparam logic [2:0] ROM_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  // Byte currently presented on the panel bus.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  // Init sequence: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h0C;
      3'd4:             rom_byte = 8'h01;
      3'd5:             rom_byte = 8'h06;
      default:          rom_byte = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [2:0]      rom_idx_q, rom_idx_n;
  lcd_byte_t       bus_q, bus_n;
  logic            en_q, en_n;
  logic            ready_q, ready_n;
  logic            done_q, done_n;
  logic            cnt_zero;
  logic            is_clr;

  assign cnt_zero = (cnt_q == '0);
  // Clear display and return home need the long execution wait.
  assign is_clr   = !bus_q.rs && ((bus_q.data == 8'h01) || (bus_q.data == 8'h02));

  // State and registered outputs; reset drops EN immediately and restarts init.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= ST_POWERUP;
      cnt_q     <= PWR_LD;
      rom_idx_q <= '0;
      bus_q     <= '0;
      en_q      <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rom_idx_q <= rom_idx_n;
      bus_q     <= bus_n;
      en_q      <= en_n;
      ready_q   <= ready_n;
      done_q    <= done_n;
    end
  end

  // Next-state, counter reloads and next output values.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    rom_idx_n = rom_idx_q;
    bus_n     = bus_q;
    en_n      = en_q;
    ready_n   = ready_q;
    done_n    = done_q;
    case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) begin
          state_n    = ST_SETUP;
          cnt_n      = SETUP_LD;
          rom_idx_n  = '0;
          bus_n.rs   = 1'b0;
          bus_n.data = rom_byte(3'd0);
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_n = ST_PULSE;
          cnt_n   = PULSE_LD;
          en_n    = 1'b1;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_n = ST_HOLD;
          cnt_n   = HOLD_LD;
          en_n    = 1'b0;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_n = ST_WAIT;
          cnt_n   = is_clr ? CLR_LD : CMD_LD;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      ST_WAIT: begin
        if (!cnt_zero) begin
          cnt_n = cnt_q - CW'(1);
        end else if (done_q || (rom_idx_q == ROM_LAST)) begin
          // Normal write finished, or the last init byte: open for upstream.
          state_n = ST_IDLE;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end else begin
          // Chain straight into the next init byte without an idle cycle.
          state_n    = ST_SETUP;
          cnt_n      = SETUP_LD;
          rom_idx_n  = rom_idx_q + 3'd1;
          bus_n.rs   = 1'b0;
          bus_n.data = rom_byte(rom_idx_q + 3'd1);
        end
      end
      ST_IDLE: begin
        if (wr_valid && ready_q) begin
          state_n    = ST_SETUP;
          cnt_n      = SETUP_LD;
          ready_n    = 1'b0;
          bus_n.rs   = wr_rs;
          bus_n.data = wr_data;
        end
      end
      default: begin
        state_n = ST_POWERUP;
        cnt_n   = PWR_LD;
      end
    endcase
  end

  assign wr_ready  = ready_q;
  assign init_done = done_q;
  assign LCD_DATA  = bus_q.data;
  assign LCD_RS    = bus_q.rs;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Bench for lcd_hd44780_writer: a negedge monitor logs EN pulses, accepts and
// ready rises; scenario tasks compare them to timings computed from the bus rules.
module tb_lcd_hd44780_writer;

  localparam int P_PWR = 10;
  localparam int P_S   = 2;
  localparam int P_E   = 3;
  localparam int P_H   = 2;
  localparam int P_CMD = 5;
  localparam int P_CLR = 20;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA;

  lcd_hd44780_writer #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_S), .EN_PULSE_CYC(P_E),
    .HOLD_CYC(P_H), .CMD_WAIT_CYC(P_CMD), .CLR_WAIT_CYC(P_CLR)
  ) dut (
    .clock_in(clock_in), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs),
    .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    int         rise;
  } pulse_t;

  pulse_t     pulses[$];
  int         acc_q[$];
  int         rdy_q[$];
  int         done_cyc = -1;
  int         rw_viol = 0;
  int         stab_viol = 0;
  pulse_t     cur;
  bit         in_pulse = 0;
  int         hold_left = 0;
  bit         rdy_prev = 0;
  bit         done_prev = 0;
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Execution wait the panel needs after a byte.
  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD;
  endfunction

  // Edge counter: value n after the nth rising edge.
  always @(posedge clock_in) cyc <= cyc + 1;

  // Bus monitor.
  always @(negedge clock_in) begin
    if (LCD_RW !== 1'b0) rw_viol++;
    if (reset) begin
      in_pulse  = 0;
      hold_left = 0;
      rdy_prev  = 0;
      done_prev = 0;
    end else begin
      if (LCD_EN === 1'b1 && !in_pulse) begin
        in_pulse = 1;
        cur.rs = LCD_RS; cur.data = LCD_DATA; cur.rise = cyc; cur.width = 1;
      end else if (LCD_EN === 1'b1) begin
        cur.width++;
        if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) stab_viol++;
      end else if (in_pulse) begin
        in_pulse = 0;
        pulses.push_back(cur);
        hold_left = P_H;
      end
      if (LCD_EN !== 1'b1 && hold_left > 0) begin
        if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) stab_viol++;
        hold_left--;
      end
      if (wr_ready && !rdy_prev) rdy_q.push_back(cyc);
      if (init_done && !done_prev) done_cyc = cyc;
      if (wr_valid && wr_ready) acc_q.push_back(cyc + 1);
      rdy_prev  = wr_ready;
      done_prev = init_done;
    end
  end

  task automatic test_reset;
    reset = 1'b1; wr_valid = 1'b0;
    repeat (3) @(negedge clock_in);
    #1;
    checks++; if (LCD_EN !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", LCD_EN); end
    checks++; if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", LCD_DATA); end
    checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
    checks++; if (LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", LCD_RW); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", init_done); end
  endtask

  // Releases reset (expects it asserted) and checks the init byte stream,
  // with random wr_valid noise that must never be accepted.
  task automatic test_init(input string tag);
    int r, t, exp_done;
    int exp_rise[6];
    pulses.delete(); rdy_q.delete(); acc_q.delete(); done_cyc = -1;
    @(posedge clock_in); #2;
    r = cyc;
    reset = 1'b0;
    t = r + P_PWR;
    for (int k = 0; k < 6; k++) begin
      exp_rise[k] = t + P_S;
      t += P_S + P_E + P_H + wait_of(1'b0, rom[k]);
    end
    exp_done = t;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock_in); #2;
      if (init_done) break;
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_rs    = 1'b1;
      wr_data  = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'($urandom);
    end
    wr_valid = 1'b0;
    @(negedge clock_in); #1;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL %s init_timeout: got %b want 1", tag, init_done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL %s init_ready: got %b want 1", tag, wr_ready); end
    checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL %s init_accepts: got %0d want 0", tag, acc_q.size()); end
    checks++; if (done_cyc !== exp_done) begin errors++; $display("FAIL %s init_done_cyc: got %0d want %0d", tag, done_cyc - r, exp_done - r); end
    checks++;
    if (rdy_q.size() < 1 || rdy_q[0] !== exp_done) begin
      errors++; $display("FAIL %s init_ready_cyc: got %0d want %0d", tag, (rdy_q.size() > 0) ? rdy_q[0] - r : -1, exp_done - r);
    end
    checks++;
    if (pulses.size() !== 6) begin
      errors++; $display("FAIL %s init_pulse_count: got %0d want 6", tag, pulses.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (pulses[k].data !== rom[k] || pulses[k].rs !== 1'b0) begin
          errors++; $display("FAIL %s init_byte%0d: got rs=%b data=%h want rs=0 data=%h", tag, k, pulses[k].rs, pulses[k].data, rom[k]); end
        checks++; if (pulses[k].width !== P_E) begin
          errors++; $display("FAIL %s init_width%0d: got %0d want %0d", tag, k, pulses[k].width, P_E); end
        checks++; if (pulses[k].rise !== exp_rise[k]) begin
          errors++; $display("FAIL %s init_rise%0d: got %0d want %0d", tag, k, pulses[k].rise - r, exp_rise[k] - r); end
      end
      checks++; if (pulses[5].rise - pulses[4].rise !== P_S + P_E + P_H + P_CLR) begin
        errors++; $display("FAIL %s clr_gap: got %0d want %0d", tag, pulses[5].rise - pulses[4].rise, P_S + P_E + P_H + P_CLR); end
    end
  endtask

  task automatic test_single(input logic rs, input logic [7:0] d);
    int t, exp_rdy;
    for (int i = 0; i < 200 && !wr_ready; i++) begin @(negedge clock_in); #1; end
    pulses.delete(); rdy_q.delete(); acc_q.delete();
    @(posedge clock_in); #2;
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) begin @(negedge clock_in); #1; end
    checks++;
    if (acc_q.size() !== 1) begin
      errors++; $display("FAIL single_accept %h: got %0d want 1", d, acc_q.size());
      wr_valid = 1'b0;
      return;
    end
    t = acc_q[0];
    exp_rdy = t + P_S + P_E + P_H + wait_of(rs, d);
    @(posedge clock_in); #2;
    wr_valid = 1'b0; wr_rs = ~rs; wr_data = ~d;
    @(negedge clock_in); #1;
    checks++; if (LCD_RS !== rs || LCD_DATA !== d) begin
      errors++; $display("FAIL single_bus_T1: got rs=%b data=%h want rs=%b data=%h", LCD_RS, LCD_DATA, rs, d); end
    checks++; if (wr_ready !== 1'b0 || LCD_EN !== 1'b0) begin
      errors++; $display("FAIL single_T1_ctrl: got ready=%b en=%b want 0 0", wr_ready, LCD_EN); end
    for (int i = 0; i < 100 && rdy_q.size() == 0; i++) begin @(negedge clock_in); #1; end
    checks++; if (rdy_q.size() < 1 || rdy_q[0] !== exp_rdy) begin
      errors++; $display("FAIL single_ready %h: got %0d want %0d", d, (rdy_q.size() > 0) ? rdy_q[0] - t : -1, exp_rdy - t); end
    checks++;
    if (pulses.size() !== 1) begin
      errors++; $display("FAIL single_pulse_count %h: got %0d want 1", d, pulses.size());
    end else begin
      checks++; if (pulses[0].rs !== rs || pulses[0].data !== d) begin
        errors++; $display("FAIL single_pulse_byte: got rs=%b data=%h want rs=%b data=%h", pulses[0].rs, pulses[0].data, rs, d); end
      checks++; if (pulses[0].rise !== t + P_S || pulses[0].width !== P_E) begin
        errors++; $display("FAIL single_pulse_time %h: got rise=%0d width=%0d want rise=%0d width=%0d", d, pulses[0].rise - t, pulses[0].width, P_S, P_E); end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 6;
    logic       rs_a [N];
    logic [7:0] d_a  [N];
    rs_a[0] = 1'b1; d_a[0] = 8'h48;
    rs_a[1] = 1'b1; d_a[1] = 8'h49;
    rs_a[2] = 1'b0; d_a[2] = 8'h01;
    for (int k = 3; k < N; k++) begin
      rs_a[k] = 1'($urandom);
      d_a[k]  = ($urandom_range(0, 3) == 0) ? 8'h02 : 8'($urandom);
    end
    for (int i = 0; i < 200 && !wr_ready; i++) begin @(negedge clock_in); #1; end
    pulses.delete(); rdy_q.delete(); acc_q.delete();
    @(posedge clock_in); #2;
    wr_valid = 1'b1; wr_rs = rs_a[0]; wr_data = d_a[0];
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 100 && acc_q.size() < k + 1; i++) begin @(negedge clock_in); #1; end
      if (acc_q.size() < k + 1) break;
      @(posedge clock_in); #2;
      if (k + 1 < N) begin wr_rs = rs_a[k + 1]; wr_data = d_a[k + 1]; end
      else wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 200 && rdy_q.size() < N; i++) begin @(negedge clock_in); #1; end
    checks++;
    if (acc_q.size() !== N || rdy_q.size() !== N || pulses.size() !== N) begin
      errors++; $display("FAIL b2b_counts: got acc=%0d rdy=%0d pulses=%0d want %0d each", acc_q.size(), rdy_q.size(), pulses.size(), N);
      return;
    end
    for (int k = 0; k < N; k++) begin
      checks++; if (pulses[k].rs !== rs_a[k] || pulses[k].data !== d_a[k] || pulses[k].width !== P_E) begin
        errors++; $display("FAIL b2b_pulse%0d: got rs=%b data=%h w=%0d want rs=%b data=%h w=%0d", k, pulses[k].rs, pulses[k].data, pulses[k].width, rs_a[k], d_a[k], P_E); end
      checks++; if (pulses[k].rise !== acc_q[k] + P_S) begin
        errors++; $display("FAIL b2b_rise%0d: got %0d want %0d", k, pulses[k].rise - acc_q[k], P_S); end
      checks++; if (rdy_q[k] !== acc_q[k] + P_S + P_E + P_H + wait_of(rs_a[k], d_a[k])) begin
        errors++; $display("FAIL b2b_ready%0d: got %0d want %0d", k, rdy_q[k] - acc_q[k], P_S + P_E + P_H + wait_of(rs_a[k], d_a[k])); end
      if (k > 0) begin
        checks++; if (acc_q[k] !== rdy_q[k - 1] + 1) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d want %0d", k, acc_q[k] - rdy_q[k - 1], 1); end
      end
    end
    checks++; if (pulses[1].rise - pulses[0].rise !== 13) begin
      errors++; $display("FAIL b2b_spacing: got %0d want 13", pulses[1].rise - pulses[0].rise); end
    checks++; if (rdy_q[2] - acc_q[2] !== 27) begin
      errors++; $display("FAIL b2b_clr_ready: got %0d want 27", rdy_q[2] - acc_q[2]); end
  endtask

  // Leaves reset asserted for the following init re-check.
  task automatic test_reset_mid_pulse;
    for (int i = 0; i < 200 && !wr_ready; i++) begin @(negedge clock_in); #1; end
    acc_q.delete();
    @(posedge clock_in); #2;
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'($urandom);
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) begin @(negedge clock_in); #1; end
    @(posedge clock_in); #2;
    wr_valid = 1'b0;
    for (int i = 0; i < 50 && LCD_EN !== 1'b1; i++) begin @(negedge clock_in); #1; end
    checks++; if (LCD_EN !== 1'b1) begin errors++; $display("FAIL midrst_en_seen: got %b want 1", LCD_EN); end
    @(posedge clock_in); #2;
    reset = 1'b1;
    #1;
    checks++; if (LCD_EN !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b want 0", LCD_EN); end
    checks++; if (LCD_DATA !== 8'h00 || LCD_RS !== 1'b0 || LCD_RW !== 1'b0) begin
      errors++; $display("FAIL midrst_bus: got data=%h rs=%b rw=%b want 00 0 0", LCD_DATA, LCD_RS, LCD_RW); end
    checks++; if (wr_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got ready=%b done=%b want 0 0", wr_ready, init_done); end
    repeat (3) @(negedge clock_in);
  endtask

  task automatic test_invariants;
    checks++; if (rw_viol !== 0) begin errors++; $display("FAIL rw_low: got %0d violations want 0", rw_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bus_stable: got %0d violations want 0", stab_viol); end
  endtask

  initial begin
    test_reset();
    test_init("first");
    test_single(1'b1, 8'h41);
    for (int k = 0; k < 4; k++) begin
      test_single(1'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom));
    end
    test_back_to_back();
    test_reset_mid_pulse();
    test_init("after_reset");
    test_single(1'b1, 8'h41);
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
